// File: rtl/match_ctrl.sv
// Volley match sequencer: start, serve hold, rally, point pause, game over, link loss.
// Optional macro MATCH_CTRL_WIN_BY_TWO_EN: a win needs a 2-point lead, and 15 wins outright.
module match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 65_000_000,
  parameter int NET_X        = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_click,
  input  logic        gnd_col,
  input  logic        ovr_touch,
  input  logic        last_touch,
  input  logic [11:0] ball_xpos,
  input  logic        con_broken,
  output logic        ball_hold,
  output logic        ball_rst,
  output logic        serve_side,
  output logic [3:0]  score_pl1,
  output logic [3:0]  score_pl2,
  output logic        point_flag,
  output logic        endgame,
  output logic        winner
);

  typedef enum logic [2:0] {IDLE, SERVE, RALLY, POINT, OVER, LINK} state_t;

  localparam logic [26:0] PAUSE_LAST = 27'(PAUSE_CYCLES - 1);
  localparam logic [4:0]  WIN_VAL    = 5'(WIN_SCORE);
  localparam logic [11:0] NET_POS    = 12'(NET_X);

  state_t      state;
  logic [26:0] cnt;
  logic        start_q, gnd_q, ovr_q;
  logic        start_ev, gnd_ev, ovr_ev;
  logic [4:0]  sum_pl1, sum_pl2;
  logic [3:0]  inc_pl1, inc_pl2;
  logic        point_ev, scorer;
  logic        win_pl1, win_pl2;

  // Events are registered edge pulses, so one input edge yields exactly one event cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      gnd_q    <= 1'b0;
      ovr_q    <= 1'b0;
      start_ev <= 1'b0;
      gnd_ev   <= 1'b0;
      ovr_ev   <= 1'b0;
    end else begin
      start_q  <= start_click;
      gnd_q    <= gnd_col;
      ovr_q    <= ovr_touch;
      start_ev <= start_click & ~start_q;
      gnd_ev   <= gnd_col & ~gnd_q;
      ovr_ev   <= ovr_touch & ~ovr_q;
    end
  end

  assign sum_pl1  = {1'b0, score_pl1} + 5'd1;
  assign sum_pl2  = {1'b0, score_pl2} + 5'd1;
  assign inc_pl1  = sum_pl1[4] ? 4'hF : sum_pl1[3:0];
  assign inc_pl2  = sum_pl2[4] ? 4'hF : sum_pl2[3:0];
  assign point_ev = ovr_ev | gnd_ev;
  // scorer: 0 = player 1, 1 = player 2; a touch violation outranks a ground hit
  assign scorer   = ovr_ev ? ~last_touch : (ball_xpos < NET_POS);

`ifdef MATCH_CTRL_WIN_BY_TWO_EN
  assign win_pl1 = (({1'b0, score_pl1} >= WIN_VAL) &&
                    ({1'b0, score_pl1} >= {1'b0, score_pl2} + 5'd2)) || (score_pl1 == 4'hF);
  assign win_pl2 = (({1'b0, score_pl2} >= WIN_VAL) &&
                    ({1'b0, score_pl2} >= {1'b0, score_pl1} + 5'd2)) || (score_pl2 == 4'hF);
`else
  assign win_pl1 = {1'b0, score_pl1} >= WIN_VAL;
  assign win_pl2 = {1'b0, score_pl2} >= WIN_VAL;
`endif

  // Match FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ball_hold  <= 1'b1;
      ball_rst   <= 1'b0;
      serve_side <= 1'b0;
      score_pl1  <= '0;
      score_pl2  <= '0;
      point_flag <= 1'b0;
      endgame    <= 1'b0;
      winner     <= 1'b0;
    end else begin
      ball_rst   <= 1'b0;
      point_flag <= 1'b0;
      cnt        <= cnt + 27'd1;
      if (con_broken && (state == SERVE || state == RALLY || state == POINT)) begin
        state     <= LINK;
        ball_hold <= 1'b1;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE, OVER: begin
            if (start_ev) begin
              state      <= SERVE;
              score_pl1  <= '0;
              score_pl2  <= '0;
              serve_side <= 1'b0;
              ball_rst   <= 1'b1;
              ball_hold  <= 1'b1;
              endgame    <= 1'b0;
              cnt        <= '0;
            end
          end
          SERVE: begin
            if (cnt == PAUSE_LAST) begin
              state     <= RALLY;
              ball_hold <= 1'b0;
              cnt       <= '0;
            end
          end
          RALLY: begin
            if (point_ev) begin
              if (scorer) score_pl2 <= inc_pl2;
              else        score_pl1 <= inc_pl1;
              serve_side <= scorer;
              point_flag <= 1'b1;
              ball_hold  <= 1'b1;
              state      <= POINT;
              cnt        <= '0;
            end
          end
          POINT: begin
            if (cnt == PAUSE_LAST) begin
              cnt <= '0;
              if (win_pl1 || win_pl2) begin
                state   <= OVER;
                endgame <= 1'b1;
                winner  <= win_pl2;
              end else begin
                state    <= SERVE;
                ball_rst <= 1'b1;
              end
            end
          end
          LINK: begin
            if (!con_broken) begin
              state    <= SERVE;
              ball_rst <= 1'b1;
              cnt      <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Game-sequencing controller for the volley datapath. It sits between the collision and referee signals (ground collision, touch-count violation, last-touch side, UART link status) and the ball and score datapath. It owns the match state machine: start, serve hold, rally, point pause, game over and link loss. It drives the ball freeze/re-serve controls, both 4-bit scores, and the end-of-game flag consumed by the score display and the UART mux.

## Interface
Parameters:
- `WIN_SCORE`, 9: points needed to win (1..15).
- `PAUSE_CYCLES`, 65_000_000: length of the serve hold and the point pause, in `clk` cycles (1 s at 65 MHz).
- `NET_X`, 512: ball x coordinate of the net. `ball_xpos < NET_X` is the player 1 half.

Ports:
- `clk` in 1: pixel clock, 65 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `start_click` in 1: local mouse left button (level).
- `gnd_col` in 1: ball touches ground (level, may last several cycles).
- `ovr_touch` in 1: touch-count violation (level).
- `last_touch` in 1: side that touched last (0 = player 1, 1 = player 2).
- `ball_xpos` in 12: current ball x position.
- `con_broken` in 1: UART link lost (level).
- `ball_hold` out 1: freeze the ball at its serve position.
- `ball_rst` out 1: one-cycle pulse to reload the ball at the server's side.
- `serve_side` out 1: side that serves next (0 = player 1, 1 = player 2).
- `score_pl1` out 4: player 1 score.
- `score_pl2` out 4: player 2 score.
- `point_flag` out 1: one-cycle pulse when a point is awarded.
- `endgame` out 1: match is over.
- `winner` out 1: winning side, valid while `endgame` = 1.

## Operation
- Rising-edge detectors on `start_click`, `gnd_col` and `ovr_touch`, built from one register each. Only edges act as events.
- States:
  - IDLE: `ball_hold`=1. A `start_click` edge clears both scores, sets `serve_side`=0, pulses `ball_rst` and goes to SERVE.
  - SERVE: `ball_hold`=1. The pause counter counts `PAUSE_CYCLES`, then the state goes to RALLY.
  - RALLY: `ball_hold`=0. Point events are evaluated here, with priority `ovr_touch` edge over `gnd_col` edge.
    - `ovr_touch`: the point goes to the side opposite `last_touch`.
    - `gnd_col`: the point goes to player 2 if `ball_xpos < NET_X`, otherwise to player 1.
    - On a point: the scorer's score increments, `serve_side` becomes the scorer, `point_flag` pulses, and the state goes to POINT.
  - POINT: `ball_hold`=1. Waits `PAUSE_CYCLES`.
    - If the win condition holds: go to OVER.
    - Otherwise: pulse `ball_rst` and go to SERVE.
  - OVER: `endgame`=1 and `ball_hold`=1. `winner` is held. A `start_click` edge behaves as in IDLE.
  - LINK: entered from SERVE, RALLY or POINT whenever `con_broken`=1. This transition has priority over all other transitions. `ball_hold`=1, scores are kept. When `con_broken` returns to 0: pulse `ball_rst`, clear the counter, go to SERVE.
- Events outside their state are ignored: ground and touch edges outside RALLY, clicks outside IDLE/OVER. They are not queued.
- Scores saturate at 15. The increment uses a 5-bit intermediate clamped to 4 bits.
- Win condition (base build): a score reaches `WIN_SCORE`.
- Pause counter: 27 bits, cleared on every state entry. Terminal count is `PAUSE_CYCLES-1`.

## Timing
- Reset values: state IDLE, `ball_hold`=1, `ball_rst`=0, `serve_side`=0, scores 0, `point_flag`=0, `endgame`=0, `winner`=0.
- All outputs are registered.
- A point is visible one cycle after the event edge: scores, `point_flag` and `serve_side` update in the same cycle. Event edge = the first cycle with the input high after it was low; the edge is registered, so input to output is 2 `clk` cycles.
- SERVE and POINT each last exactly `PAUSE_CYCLES` cycles.
- `ball_rst` is asserted in the first cycle of SERVE.
- `endgame` rises in the cycle after POINT terminates.
- `ovr_touch` and `gnd_col` edges in the same cycle: exactly one point, decided by `ovr_touch`.
- `con_broken` in the same cycle as a point event: go to LINK with no point awarded.
- `rst` asserted mid-rally: all state returns immediately to reset values (asynchronous).

## Configuration
- `MATCH_CTRL_WIN_BY_TWO_EN` defined:
  - Win requires score ≥ `WIN_SCORE` and a lead of at least 2 over the opponent.
  - Reaching 15 wins unconditionally, so saturation cannot deadlock the match.
- Not defined: first to `WIN_SCORE` wins. No margin logic is synthesized.

## Test plan
- Reset, then `start_click` edge with `PAUSE_CYCLES`=4 → `ball_rst` pulse, `ball_hold`=1 for 4 cycles, then 0 (RALLY).
- RALLY, `gnd_col` edge with `ball_xpos`=100 → `score_pl2`=1, `serve_side`=1, one `point_flag` pulse. A `gnd_col` held high for 10 cycles awards only one point.
- RALLY, `ovr_touch` and `gnd_col` edges together, `last_touch`=1, `ball_xpos`=900 → `score_pl1`=1 only.
- `WIN_SCORE`=3, player 1 scores 3 points → after the POINT pause `endgame`=1, `winner`=0. A later `start_click` clears both scores to 0.
- With `MATCH_CTRL_WIN_BY_TWO_EN`, `WIN_SCORE`=3, score 3:3 then player 1 scores → no `endgame`. Player 1 scores again (5:3) → `endgame`=1, `winner`=0.
- RALLY at 2:1, `con_broken`=1 for 20 cycles → `ball_hold`=1, scores stay 2:1. On release: `ball_rst` pulse, then SERVE.
